// File: rtl/pbuff_write_sched.sv
// Pixel-buffer write scheduler: one write per clock, CPU PIO writes win over the
// rectangle-fill engine, which stalls in place and resumes on the next free cycle.
// Ports: clk_clk/reset_reset_n; cpu_adr/cpu_data/cpu_wren (edge-requested PIO write);
// fill_start/fill_abort/fill_x0/fill_y0/fill_w/fill_h/fill_colour (fill control);
// pb_adr/pb_data/pb_wren (registered buffer write port); fill_busy/fill_done (status).
module pbuff_write_sched #(
    parameter int WIDTH  = 160,
    parameter int HEIGHT = 120,
    parameter int ADDR_W = 15,
    parameter int DATA_W = 4,
    parameter int X_W    = 8,
    parameter int Y_W    = 7
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic [ADDR_W-1:0] cpu_adr,
    input  logic [DATA_W-1:0] cpu_data,
    input  logic              cpu_wren,
    input  logic              fill_start,
    input  logic              fill_abort,
    input  logic [X_W-1:0]    fill_x0,
    input  logic [Y_W-1:0]    fill_y0,
    input  logic [X_W-1:0]    fill_w,
    input  logic [Y_W-1:0]    fill_h,
    input  logic [DATA_W-1:0] fill_colour,
    output logic [ADDR_W-1:0] pb_adr,
    output logic [DATA_W-1:0] pb_data,
    output logic              pb_wren,
    output logic              fill_busy,
    output logic              fill_done
);

    typedef enum logic {IDLE, FILL} state_t;

    localparam logic [X_W:0]      WIDTH_E  = WIDTH[X_W:0];
    localparam logic [Y_W:0]      HEIGHT_E = HEIGHT[Y_W:0];
    localparam logic [ADDR_W-1:0] WIDTH_A  = WIDTH[ADDR_W-1:0];

    state_t            state;
    logic              cpu_wren_q;
    logic [DATA_W-1:0] colour_q;
    logic [X_W-1:0]    x0_q;
    logic [X_W-1:0]    w_q;
    logic [Y_W-1:0]    h_q;
    logic [X_W-1:0]    col;
    logic [Y_W-1:0]    row;
    logic [ADDR_W-1:0] row_base;

    logic              cpu_req;
    logic [X_W:0]      w_room;
    logic [Y_W:0]      h_room;
    logic [X_W-1:0]    w_clip;
    logic [Y_W-1:0]    h_clip;
    logic              last_col;
    logic              last_row;
    logic [ADDR_W-1:0] fill_adr;

    // Constant multiply by WIDTH as a sum of shifted copies of y.
    function automatic logic [ADDR_W-1:0] times_width(input logic [Y_W-1:0] y);
        logic [ADDR_W-1:0] acc;
        acc = '0;
        for (int i = 0; i < ADDR_W; i++) begin
            if (WIDTH_A[i]) acc = acc + (ADDR_W'(y) << i);
        end
        return acc;
    endfunction

    assign cpu_req = cpu_wren & ~cpu_wren_q;

    // Clip the requested rectangle against the right and bottom edges.
    always_comb begin
        w_room = '0;
        h_room = '0;
        w_clip = '0;
        h_clip = '0;
        if ({1'b0, fill_x0} < WIDTH_E) begin
            w_room = WIDTH_E - {1'b0, fill_x0};
            w_clip = ({1'b0, fill_w} < w_room) ? fill_w : w_room[X_W-1:0];
        end
        if ({1'b0, fill_y0} < HEIGHT_E) begin
            h_room = HEIGHT_E - {1'b0, fill_y0};
            h_clip = ({1'b0, fill_h} < h_room) ? fill_h : h_room[Y_W-1:0];
        end
    end

    assign last_col = (col == w_q - X_W'(1));
    assign last_row = (row == h_q - Y_W'(1));
    assign fill_adr = row_base + ADDR_W'(x0_q) + ADDR_W'(col);

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state      <= IDLE;
            cpu_wren_q <= 1'b0;
            colour_q   <= '0;
            x0_q       <= '0;
            w_q        <= '0;
            h_q        <= '0;
            col        <= '0;
            row        <= '0;
            row_base   <= '0;
            pb_adr     <= '0;
            pb_data    <= '0;
            pb_wren    <= 1'b0;
            fill_busy  <= 1'b0;
            fill_done  <= 1'b0;
        end else begin
            cpu_wren_q <= cpu_wren;
            pb_wren    <= 1'b0;
            fill_done  <= 1'b0;
            if (cpu_req) begin
                pb_adr  <= cpu_adr;
                pb_data <= cpu_data;
                pb_wren <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (fill_start) begin
                        colour_q <= fill_colour;
                        x0_q     <= fill_x0;
                        w_q      <= w_clip;
                        h_q      <= h_clip;
                        col      <= '0;
                        row      <= '0;
                        row_base <= times_width(fill_y0);
                        if (w_clip == '0 || h_clip == '0) begin
                            fill_done <= 1'b1;
                        end else begin
                            state     <= FILL;
                            fill_busy <= 1'b1;
                        end
                    end
                end
                FILL: begin
                    if (fill_abort) begin
                        state     <= IDLE;
                        fill_busy <= 1'b0;
                        fill_done <= 1'b1;
                    end else if (!cpu_req) begin
                        pb_adr  <= fill_adr;
                        pb_data <= colour_q;
                        pb_wren <= 1'b1;
                        if (last_col) begin
                            col      <= '0;
                            row      <= row + Y_W'(1);
                            row_base <= row_base + WIDTH_A;
                            if (last_row) begin
                                state     <= IDLE;
                                fill_busy <= 1'b0;
                                fill_done <= 1'b1;
                            end
                        end else begin
                            col <= col + X_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pbuff_write_sched.sv
// Self-checking bench for pbuff_write_sched: directed scenarios plus randomized
// fills with CPU interference, each cycle checked against a queue-based model.
module tb_pbuff_write_sched;

    localparam int W = 160;
    localparam int H = 120;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [14:0] cpu_adr;
    logic [3:0]  cpu_data;
    logic        cpu_wren;
    logic        fill_start;
    logic        fill_abort;
    logic [7:0]  fill_x0;
    logic [6:0]  fill_y0;
    logic [7:0]  fill_w;
    logic [6:0]  fill_h;
    logic [3:0]  fill_colour;
    logic [14:0] pb_adr;
    logic [3:0]  pb_data;
    logic        pb_wren;
    logic        fill_busy;
    logic        fill_done;

    pbuff_write_sched dut (
        .clk_clk(clk),
        .reset_reset_n(rst_n),
        .cpu_adr(cpu_adr),
        .cpu_data(cpu_data),
        .cpu_wren(cpu_wren),
        .fill_start(fill_start),
        .fill_abort(fill_abort),
        .fill_x0(fill_x0),
        .fill_y0(fill_y0),
        .fill_w(fill_w),
        .fill_h(fill_h),
        .fill_colour(fill_colour),
        .pb_adr(pb_adr),
        .pb_data(pb_data),
        .pb_wren(pb_wren),
        .fill_busy(fill_busy),
        .fill_done(fill_done)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int failed = 0;

    // Reference model: pending fill pixels as a queue of addresses.
    int   q_adr[$];
    logic m_busy = 1'b0;
    logic m_cpu_q = 1'b0;
    int   m_colour = 0;
    int   m_adr = 0;
    int   m_data = 0;

    int wr_count = 0;
    int done_count = 0;
    int wr_log[$];
    int dat_log[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q_adr.delete();
        m_busy = 1'b0;
        m_cpu_q = 1'b0;
        m_adr = 0;
        m_data = 0;
    endtask

    task automatic step();
        logic req;
        logic e_wren;
        logic e_done;
        int wc;
        int hc;
        @(posedge clk);
        e_wren = 1'b0;
        e_done = 1'b0;
        req = cpu_wren && !m_cpu_q;
        m_cpu_q = cpu_wren;
        if (req) begin
            e_wren = 1'b1;
            m_adr = int'(cpu_adr);
            m_data = int'(cpu_data);
        end
        if (m_busy) begin
            if (fill_abort) begin
                q_adr.delete();
                m_busy = 1'b0;
                e_done = 1'b1;
            end else if (!req) begin
                e_wren = 1'b1;
                m_adr = q_adr.pop_front();
                m_data = m_colour;
                if (q_adr.size() == 0) begin
                    m_busy = 1'b0;
                    e_done = 1'b1;
                end
            end
        end else if (fill_start) begin
            wc = (int'(fill_x0) >= W) ? 0 : W - int'(fill_x0);
            if (int'(fill_w) < wc) wc = int'(fill_w);
            hc = (int'(fill_y0) >= H) ? 0 : H - int'(fill_y0);
            if (int'(fill_h) < hc) hc = int'(fill_h);
            m_colour = int'(fill_colour);
            for (int r = 0; r < hc; r++)
                for (int c = 0; c < wc; c++)
                    q_adr.push_back((int'(fill_y0) + r) * W + int'(fill_x0) + c);
            if (q_adr.size() == 0) e_done = 1'b1;
            else m_busy = 1'b1;
        end
        #1;
        check("pb_wren", pb_wren, e_wren);
        check("pb_adr", pb_adr, m_adr);
        check("pb_data", pb_data, m_data);
        check("fill_busy", fill_busy, m_busy);
        check("fill_done", fill_done, e_done);
        if (pb_wren === 1'b1) begin
            wr_count++;
            wr_log.push_back(int'(pb_adr));
            dat_log.push_back(int'(pb_data));
        end
        if (fill_done === 1'b1) done_count++;
    endtask

    task automatic clear_logs();
        wr_count = 0;
        done_count = 0;
        wr_log.delete();
        dat_log.delete();
    endtask

    task automatic fill(input int x0, input int y0, input int w, input int h, input int c);
        fill_x0 = 8'(x0);
        fill_y0 = 7'(y0);
        fill_w = 8'(w);
        fill_h = 7'(h);
        fill_colour = 4'(c);
        fill_start = 1'b1;
        step();
        fill_start = 1'b0;
    endtask

    task automatic run_idle(input int cap);
        for (int i = 0; i < cap && m_busy; i++) step();
        check("fill_ends", fill_busy, 1'b0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_adr"}, pb_adr, 0);
        check({tag, "_data"}, pb_data, 0);
        check({tag, "_wren"}, pb_wren, 0);
        check({tag, "_busy"}, fill_busy, 0);
        check({tag, "_done"}, fill_done, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        cpu_adr = '0;
        cpu_data = '0;
        cpu_wren = 1'b0;
        fill_start = 1'b0;
        fill_abort = 1'b0;
        fill_x0 = '0;
        fill_y0 = '0;
        fill_w = '0;
        fill_h = '0;
        fill_colour = '0;
        #12;
        check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        step();
        step();

        // Held CPU strobe gives one write.
        clear_logs();
        cpu_adr = 15'h1234;
        cpu_data = 4'hA;
        cpu_wren = 1'b1;
        for (int i = 0; i < 5; i++) step();
        cpu_wren = 1'b0;
        step();
        check("cpu_hold_count", wr_count, 1);
        if (wr_log.size() > 0) begin
            check("cpu_hold_adr", wr_log[0], 32'h1234);
            check("cpu_hold_data", dat_log[0], 32'hA);
        end

        // Full-screen clear.
        clear_logs();
        fill(0, 0, 160, 120, 0);
        run_idle(20000);
        check("full_count", wr_count, W * H);
        if (wr_log.size() > 0) check("full_last", wr_log[wr_log.size()-1], W * H - 1);
        step();
        check("full_done_count", done_count, 1);

        // Clipped at the bottom-right corner.
        clear_logs();
        fill(150, 118, 20, 5, 7);
        run_idle(100);
        check("clip_count", wr_count, 20);
        if (wr_log.size() == 20)
            for (int i = 0; i < 20; i++)
                check("clip_adr", wr_log[i], (i < 10) ? 19030 + i : 19180 + i);

        // Empty fills.
        clear_logs();
        fill(5, 5, 0, 3, 1);
        step();
        fill(200, 5, 10, 3, 1);
        step();
        check("empty_writes", wr_count, 0);
        check("empty_done", done_count, 2);

        // CPU collision on the second fill cycle.
        clear_logs();
        fill(10, 10, 4, 1, 3);
        step();
        cpu_adr = 15'd5;
        cpu_data = 4'hF;
        cpu_wren = 1'b1;
        step();
        cpu_wren = 1'b0;
        run_idle(20);
        step();
        check("coll_count", wr_count, 5);
        if (wr_log.size() == 5) begin
            check("coll_a0", wr_log[0], 1610);
            check("coll_a1", wr_log[1], 5);
            check("coll_d1", dat_log[1], 4'hF);
            check("coll_a2", wr_log[2], 1611);
            check("coll_a4", wr_log[4], 1613);
        end

        // Abort after 100 writes.
        clear_logs();
        fill(0, 0, 160, 120, 2);
        for (int i = 0; i < 100; i++) step();
        fill_abort = 1'b1;
        step();
        fill_abort = 1'b0;
        for (int i = 0; i < 10; i++) step();
        check("abort_writes", wr_count, 100);
        check("abort_done", done_count, 1);

        // Reset in the middle of a fill.
        clear_logs();
        fill(0, 0, 160, 120, 9);
        for (int i = 0; i < 50; i++) step();
        rst_n = 1'b0;
        #2;
        check_zero("midreset");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        done_count = 0;
        wr_count = 0;
        for (int i = 0; i < 10; i++) step();
        check("midreset_done", done_count, 0);
        check("midreset_writes", wr_count, 0);

        // Randomized fills with CPU interference, aborts and ignored restarts.
        for (int n = 0; n < 40; n++) begin
            fill($urandom_range(0, 200), $urandom_range(0, 127),
                 $urandom_range(0, 30), $urandom_range(0, 6), $urandom_range(0, 15));
            for (int i = 0; i < 1000 && m_busy; i++) begin
                cpu_adr = 15'($urandom);
                cpu_data = 4'($urandom);
                cpu_wren = ($urandom_range(0, 2) == 0);
                fill_abort = ($urandom_range(0, 63) == 0);
                fill_start = ($urandom_range(0, 31) == 0);
                step();
                fill_abort = 1'b0;
                fill_start = 1'b0;
            end
            cpu_wren = 1'b0;
            step();
            check("rand_idle", fill_busy, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/pbuff_write_sched.md
Name: pbuff_write_sched

Overview:
- Single owner of the pixel-buffer write port (address, 4-bit pixel, write enable).
- Shares the port between two sources:
  - Nios PIO write path: address, data and wren driven by software.
  - A hardware rectangle-fill engine, used for clears and solid blocks.
- Issues at most one pixel write per clock. CPU writes always win. The fill engine stalls, without losing position, whenever a CPU write is granted.

Parameters:
- WIDTH, 160, pixels per row; row stride of the linear buffer.
- HEIGHT, 120, number of rows.
- ADDR_W, 15, pixel-buffer address width.
- DATA_W, 4, pixel data width.
- X_W, 8, x coordinate/width field width.
- Y_W, 7, y coordinate/height field width.

Ports:
- clk_clk  in  1  system clock.
- reset_reset_n  in  1  asynchronous active-low reset.
- cpu_adr  in  ADDR_W  PIO pixel address.
- cpu_data  in  DATA_W  PIO pixel data.
- cpu_wren  in  1  PIO write strobe (level); each rising edge requests one write.
- fill_start  in  1  single-cycle pulse; latches fill_x0/y0/w/h/colour.
- fill_abort  in  1  terminates an active fill.
- fill_x0  in  X_W  rectangle left column.
- fill_y0  in  Y_W  rectangle top row.
- fill_w  in  X_W  rectangle width in pixels.
- fill_h  in  Y_W  rectangle height in rows.
- fill_colour  in  DATA_W  fill pixel value.
- pb_adr  out  ADDR_W  pixel-buffer write address (registered).
- pb_data  out  DATA_W  pixel-buffer write data (registered).
- pb_wren  out  1  pixel-buffer write enable (registered, one cycle per pixel).
- fill_busy  out  1  high while a fill is active.
- fill_done  out  1  one-cycle pulse at fill completion or abort.

Behaviour:
Reset:
- Async reset zeroes all outputs, state = IDLE, cpu_wren_q = 0.
- Reset mid-fill discards the fill entirely; no resume.

CPU path:
- cpu_wren_q registers cpu_wren. A CPU request exists in any cycle where cpu_wren=1 and cpu_wren_q=0.
- On that clock edge: pb_adr<=cpu_adr, pb_data<=cpu_data, pb_wren<=1.
- Latency is one cycle. Held-high cpu_wren produces exactly one write.

Fill engine: states IDLE, FILL.
- IDLE:
  - fill_start=1 latches colour and computes clipped extents:
    - w' = min(fill_w, WIDTH-fill_x0), or 0 if fill_x0>=WIDTH.
    - h' = min(fill_h, HEIGHT-fill_y0), or 0 if fill_y0>=HEIGHT.
  - If w'=0 or h'=0: fill_done pulses on the next cycle, no writes, stay IDLE.
  - Otherwise:
    - row_base <= fill_y0*WIDTH, col <= 0, row <= 0, state <= FILL.
    - fill_y0*WIDTH is formed by shift-add; no multiplier required in the fill loop.
- FILL, each cycle with no CPU request:
  - pb_adr <= row_base + fill_x0 + col, pb_data <= colour, pb_wren <= 1.
  - Advance: if col = w'-1 then col<=0, row<=row+1, row_base<=row_base+WIDTH; else col<=col+1.
  - When the last pixel (row=h'-1, col=w'-1) is registered: state<=IDLE and fill_done<=1 on the same edge, so fill_done is high in the same cycle as the final pb_wren.
- Collision: a CPU request in FILL wins. The CPU write is issued and the fill counters hold; fill output resumes the next free cycle.
- fill_start while FILL: ignored.
- fill_abort in FILL: state<=IDLE, fill_done pulses, no further fill writes. A fill write on that same edge is suppressed; a CPU write on that same edge still issues.

Status and idle output:
- fill_busy = (state==FILL), registered.
- Pixels written by a fill = w'*h' exactly. Address sequence is row-major ascending. Addresses never reach or exceed WIDTH*HEIGHT.
- pb_wren=0 in any cycle with no grant; pb_adr/pb_data hold their last values.

Test Plan:
- Reset, then raise cpu_wren once with adr=0x1234, data=0xA and hold it high 5 cycles -> exactly one pb_wren pulse, one cycle after the edge, with adr 0x1234, data 0xA.
- fill x0=0,y0=0,w=160,h=120,colour=0x0 -> 19200 consecutive writes at addr 0..19199; fill_done coincides with the addr-19199 write; fill_busy is low afterwards.
- fill x0=150,y0=118,w=20,h=5,colour=0x7 -> clipped to 10x2 = 20 writes, at addrs 19030..19039 then 19190..19199.
- fill w=0 (or x0=200) -> fill_done pulse one cycle later, zero pb_wren, fill_busy stays 0.
- fill x0=10,y0=10,w=4,h=1, with a CPU edge (adr=5, data=0xF) on the 2nd fill cycle -> write sequence 1610, 5(0xF), 1611, 1612, 1613; total 5 writes.
- fill 160x120 started, then fill_abort after 100 writes -> no further fill writes and one fill_done pulse. Repeat the fill with reset_reset_n low mid-fill -> all outputs 0 immediately, no fill_done.
